coord_stepper: RTL
==================

COORD_STEPPER -- requirements
Module: coord_stepper

Interface
REQ-001 SHALL have parameter W, default 16: width of every coordinate and delta, signed two's complement.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port frame_start  in  1  one-cycle pulse, start of frame.
REQ-005 SHALL have port line_start  in  1  one-cycle pulse, start of visible line.
REQ-006 SHALL have port pix_en  in  1  advance to the next pixel.
REQ-007 SHALL have ports org_x, org_y, org_x2, org_y2  in  W each  frame origin for the four lanes.
REQ-008 SHALL have ports dh_x, dh_y, dh_x2, dh_y2  in  W each  per-pixel deltas.
REQ-009 SHALL have ports dv_x, dv_y, dv_x2, dv_y2  in  W each  per-line deltas.
REQ-010 SHALL have ports x_out, y_out, x2_out, y2_out  out  W each  registered current-pixel coordinates that feed the 2-step vectoring CORDIC.
REQ-011 SHALL have port active  out  1  high while in RUN.

Function
REQ-012 SHALL be a 3-state FSM: IDLE, ARMED, RUN.
REQ-013 frame_start in any state SHALL: latch all origin and delta inputs into shadow registers, load the line accumulators with origin, and go to ARMED.
REQ-014 line_start in ARMED SHALL copy the line accumulators to the pixel accumulators without adding dv, then go to RUN.
REQ-015 line_start in RUN SHALL add shadow dv to the line accumulators and load the pixel accumulators with the sum in the same cycle; state stays RUN.
REQ-016 line_start in IDLE SHALL be ignored.
REQ-017 pix_en in RUN with no line_start or frame_start SHALL add shadow dh to the pixel accumulators.
REQ-018 pix_en in IDLE or ARMED SHALL be ignored.
REQ-019 Priority SHALL be frame_start > line_start > pix_en.
REQ-020 frame_start together with line_start SHALL load origin into the line and pixel accumulators and enter RUN; this line counts as line 0.
REQ-021 A pix_en that coincides with line_start SHALL be dropped.
REQ-022 Outputs SHALL equal the pixel accumulators; an update is visible the cycle after its triggering edge (latency 1).
REQ-023 For pixel n of line m, the outputs SHALL equal org + m*dv + n*dh, modulo 2^W.
REQ-024 All additions SHALL be W-bit and wrap on overflow, with no saturation.
REQ-025 Changes on origin or delta inputs between frame_start pulses SHALL NOT affect the outputs.
REQ-026 active SHALL be registered and high exactly while the state is RUN.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, all accumulators and shadow registers to 0, all outputs to 0, and active to 0.
REQ-028 Reset asserted mid-line SHALL discard all progress; after release, outputs SHALL hold 0 until the next frame_start.

Structure
REQ-029 A shared package SHALL hold W, the state encoding (IDLE=0, ARMED=1, RUN=2), and the lane count (4).
REQ-030 Sub-module coord_lane SHALL hold one lane's shadow dh/dv, line accumulator and pixel accumulator, with load/step controls, and SHALL be instantiated 4 times.
REQ-031 The FSM and priority decode SHALL live in coord_stepper only.

Verification
REQ-032 Reset, then frame_start with org_x=100, dh_x=3, dv_x=-50, then line_start, then 4 pix_en -> x_out sequence 100,103,106,109,112; active=1.
REQ-033 Same setup, second line_start after 4 pix_en -> x_out=50; then pix_en -> 53.
REQ-034 org_y=0x7FFE, dh_y=1, 3 pix_en -> y_out 0x7FFE, 0x7FFF, 0x8000, 0x8001 (wrap).
REQ-035 Change dh_x to 10 mid-frame, pix_en -> step stays 3; after the next frame_start plus line_start, step is 10.
REQ-036 frame_start and line_start together with pix_en -> outputs=org, state RUN, pix_en dropped; line_start in IDLE -> outputs stay 0.
REQ-037 Drop rst_n mid-RUN -> all outputs 0 and active 0 asynchronously; pix_en after release -> no change.

Source files
------------

// File: rtl/coord_stepper_pkg.sv
// -----------------------------------------------------------------------------
// coord_stepper_pkg
// Shared definitions for the coordinate stepper:
//   COORD_W    - default coordinate / delta width (signed two's complement)
//   NUM_LANES  - number of coordinate lanes (x, y, x2, y2)
//   state_e    - stepper FSM state encoding
// -----------------------------------------------------------------------------
package coord_stepper_pkg;

  localparam int COORD_W   = 16;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage : coord_stepper_pkg

// File: rtl/coord_stepper_lane.sv
// -----------------------------------------------------------------------------
// coord_lane
// One coordinate lane: shadow per-pixel / per-line deltas, a line accumulator
// and a pixel accumulator. All sums are W-bit and wrap silently.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   frame_load_i   - capture dh/dv into the shadows, line accumulator <= org
//   frame_pix_i    - with frame_load_i: pixel accumulator <= org as well
//   line_copy_i    - pixel accumulator <= line accumulator
//   line_step_i    - line accumulator += dv, pixel accumulator <= that sum
//   pix_step_i     - pixel accumulator += dh
//   org_i, dh_i, dv_i - frame origin and deltas (only sampled on frame_load_i)
//   pix_o          - pixel accumulator (registered coordinate)
// Controls are decoded by the parent; at most one of them is expected per
// cycle, but the lane still resolves them in priority order.
// -----------------------------------------------------------------------------
module coord_lane #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_load_i,
  input  logic         frame_pix_i,
  input  logic         line_copy_i,
  input  logic         line_step_i,
  input  logic         pix_step_i,
  input  logic [W-1:0] org_i,
  input  logic [W-1:0] dh_i,
  input  logic [W-1:0] dv_i,
  output logic [W-1:0] pix_o
);

  logic [W-1:0] dh_q,   dh_d;
  logic [W-1:0] dv_q,   dv_d;
  logic [W-1:0] line_q, line_d;
  logic [W-1:0] pix_q,  pix_d;
  logic [W-1:0] line_sum;

  assign line_sum = line_q + dv_q;

  always_comb begin
    dh_d   = dh_q;
    dv_d   = dv_q;
    line_d = line_q;
    pix_d  = pix_q;
    if (frame_load_i) begin
      dh_d   = dh_i;
      dv_d   = dv_i;
      line_d = org_i;
      if (frame_pix_i) begin
        pix_d = org_i;
      end
    end else if (line_copy_i) begin
      pix_d = line_q;
    end else if (line_step_i) begin
      // The new line's first pixel is the advanced line accumulator itself.
      line_d = line_sum;
      pix_d  = line_sum;
    end else if (pix_step_i) begin
      pix_d = pix_q + dh_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dh_q   <= '0;
      dv_q   <= '0;
      line_q <= '0;
      pix_q  <= '0;
    end else begin
      dh_q   <= dh_d;
      dv_q   <= dv_d;
      line_q <= line_d;
      pix_q  <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule : coord_lane

// File: rtl/coord_stepper.sv
// -----------------------------------------------------------------------------
// coord_stepper
// Steps four coordinate lanes (x, y, x2, y2) across a raster so that pixel n
// of line m reads org + m*dv + n*dh (mod 2^W). Origins and deltas are
// captured on frame_start and held for the whole frame.
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   frame_start                 - start of frame (highest priority)
//   line_start                  - start of visible line
//   pix_en                      - advance one pixel (RUN only)
//   org_x/_y/_x2/_y2            - frame origins
//   dh_x/_y/_x2/_y2             - per-pixel deltas
//   dv_x/_y/_x2/_y2             - per-line deltas
//   x_out/y_out/x2_out/y2_out   - registered current-pixel coordinates
//   active                      - registered, high while in RUN
// -----------------------------------------------------------------------------
module coord_stepper
  import coord_stepper_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  input  logic         line_start,
  input  logic         pix_en,
  input  logic [W-1:0] org_x,
  input  logic [W-1:0] org_y,
  input  logic [W-1:0] org_x2,
  input  logic [W-1:0] org_y2,
  input  logic [W-1:0] dh_x,
  input  logic [W-1:0] dh_y,
  input  logic [W-1:0] dh_x2,
  input  logic [W-1:0] dh_y2,
  input  logic [W-1:0] dv_x,
  input  logic [W-1:0] dv_y,
  input  logic [W-1:0] dv_x2,
  input  logic [W-1:0] dv_y2,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] x2_out,
  output logic [W-1:0] y2_out,
  output logic         active
);

  state_e state_q, state_d;
  logic   active_q;

  logic frame_load, frame_pix, line_copy, line_step, pix_step;

  logic [W-1:0] org_a [NUM_LANES];
  logic [W-1:0] dh_a  [NUM_LANES];
  logic [W-1:0] dv_a  [NUM_LANES];
  logic [W-1:0] pix_a [NUM_LANES];

  assign org_a[0] = org_x;
  assign org_a[1] = org_y;
  assign org_a[2] = org_x2;
  assign org_a[3] = org_y2;
  assign dh_a[0]  = dh_x;
  assign dh_a[1]  = dh_y;
  assign dh_a[2]  = dh_x2;
  assign dh_a[3]  = dh_y2;
  assign dv_a[0]  = dv_x;
  assign dv_a[1]  = dv_y;
  assign dv_a[2]  = dv_x2;
  assign dv_a[3]  = dv_y2;

  // Priority decode: frame_start > line_start > pix_en. A pix_en that
  // coincides with either start pulse is dropped.
  always_comb begin
    state_d    = state_q;
    frame_load = 1'b0;
    frame_pix  = 1'b0;
    line_copy  = 1'b0;
    line_step  = 1'b0;
    pix_step   = 1'b0;
    if (frame_start) begin
      frame_load = 1'b1;
      if (line_start) begin
        // Combined pulse: origin is line 0, pixel 0, straight into RUN.
        frame_pix = 1'b1;
        state_d   = ST_RUN;
      end else begin
        state_d   = ST_ARMED;
      end
    end else if (line_start) begin
      unique case (state_q)
        ST_ARMED: begin
          line_copy = 1'b1;
          state_d   = ST_RUN;
        end
        ST_RUN:   line_step = 1'b1;
        default:  ;
      endcase
    end else if (pix_en && (state_q == ST_RUN)) begin
      pix_step = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= (state_d == ST_RUN);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      coord_lane #(.W(W)) u_lane (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_load_i (frame_load),
        .frame_pix_i  (frame_pix),
        .line_copy_i  (line_copy),
        .line_step_i  (line_step),
        .pix_step_i   (pix_step),
        .org_i        (org_a[gi]),
        .dh_i         (dh_a[gi]),
        .dv_i         (dv_a[gi]),
        .pix_o        (pix_a[gi])
      );
    end
  endgenerate

  assign x_out  = pix_a[0];
  assign y_out  = pix_a[1];
  assign x2_out = pix_a[2];
  assign y2_out = pix_a[3];
  assign active = active_q;

endmodule : coord_stepper
